// File: rtl/vga_pkg.sv
// Shared vertical timing description and helpers for the VGA raster generator.
package vga_pkg;

    typedef struct packed {
        logic [15:0] sync;
        logic [15:0] back;
        logic [15:0] active;
        logic [15:0] front;
    } vga_vtiming_t;

    localparam vga_vtiming_t VGA_V_480 = '{sync: 16'd2, back: 16'd33, active: 16'd480, front: 16'd10};
    localparam vga_vtiming_t VGA_V_400 = '{sync: 16'd2, back: 16'd35, active: 16'd400, front: 16'd12};

    function automatic logic [15:0] vtotal(input vga_vtiming_t t);
        return t.sync + t.back + t.active + t.front;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; every stage resets to RST_VAL, DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int                 WIDTH   = 1,
    parameter int                 DEPTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, reset, en};
        assign dout        = din;
    end else begin : g_stages
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
            if (en) begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
            end
        end

        // NOTE: this array is a handful of flops, not RAM, so every stage takes the reset value.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, frame-locked vertical mode, zero-latency fetch decode,
// delay-matched sync/blank outputs and one-clock line/frame/vblank event pulses.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT       = 16,
    parameter int V_SYNC        = VGA_V_480.sync,
    parameter int V_BACK        = VGA_V_480.back,
    parameter int V_ACTIVE      = VGA_V_480.active,
    parameter int V_FRONT       = VGA_V_480.front,
    parameter int ALT_V_SYNC    = VGA_V_400.sync,
    parameter int ALT_V_BACK    = VGA_V_400.back,
    parameter int ALT_V_ACTIVE  = VGA_V_400.active,
    parameter int ALT_V_FRONT   = VGA_V_400.front,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter bit ALT_VSYNC_POL = 1'b1,
    parameter int PIPE_DELAY    = 2,
    parameter int CW            = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          mode_sel,
    output logic          mode_active,
    output logic          hsync,
    output logic          vsync,
    output logic          is_blank,
    output logic          fetch_valid,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

    localparam vga_vtiming_t VT0 = '{sync: 16'(V_SYNC), back: 16'(V_BACK),
                                     active: 16'(V_ACTIVE), front: 16'(V_FRONT)};
    localparam vga_vtiming_t VT1 = '{sync: 16'(ALT_V_SYNC), back: 16'(ALT_V_BACK),
                                     active: 16'(ALT_V_ACTIVE), front: 16'(ALT_V_FRONT)};

    // Region bounds carry one extra bit so an end bound equal to 2**CW still compares correctly.
    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW:0]   H_SYNC_END  = (CW+1)'(H_SYNC);
    localparam logic [CW:0]   H_ACT_START = (CW+1)'(H_SYNC + H_BACK);
    localparam logic [CW:0]   H_ACT_END   = (CW+1)'(H_SYNC + H_BACK + H_ACTIVE);

    if ((H_TOTAL - 1) >= (1 << CW) || (int'(vtotal(VT0)) - 1) >= (1 << CW) ||
        (int'(vtotal(VT1)) - 1) >= (1 << CW)) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for the configured totals");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_pipe_check
        $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          mode_active_q, mode_active_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          vblank_start_q, vblank_start_d;

    vga_vtiming_t  vt;
    logic          v_pol;
    logic          h_last, v_last;
    logic [CW:0]   v_sync_end, v_act_start, v_act_end;
    logic          h_in, v_in;
    logic          hsync_raw, vsync_raw, blank_raw;

    // Vertical geometry and sync level always follow the mode locked in at the last frame wrap.
    always_comb begin
        vt          = mode_active_q ? VT1 : VT0;
        v_pol       = mode_active_q ? ALT_VSYNC_POL : VSYNC_POL;
        h_last      = (hcount_q == H_LAST);
        v_last      = (vcount_q == CW'(vtotal(vt) - 16'd1));
        v_sync_end  = (CW+1)'(vt.sync);
        v_act_start = (CW+1)'(vt.sync + vt.back);
        v_act_end   = (CW+1)'(vt.sync + vt.back + vt.active);
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        hcount_d       = hcount_q;
        vcount_d       = vcount_q;
        mode_active_d  = mode_active_q;
        line_start_d   = 1'b0;
        frame_start_d  = 1'b0;
        vblank_start_d = 1'b0;
        if (pix_en) begin
            if (h_last) begin
                hcount_d     = '0;
                line_start_d = 1'b1;
                if (v_last) begin
                    vcount_d      = '0;
                    mode_active_d = mode_sel;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d       = vcount_q + CW'(1);
                    vblank_start_d = ({1'b0, vcount_d} == v_act_end);
                end
            end else begin
                hcount_d = hcount_q + CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_q       <= '0;
            vcount_q       <= '0;
            mode_active_q  <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hcount_q       <= hcount_d;
            vcount_q       <= vcount_d;
            mode_active_q  <= mode_active_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    always_comb begin
        h_in        = ({1'b0, hcount_q} >= H_ACT_START) && ({1'b0, hcount_q} < H_ACT_END);
        v_in        = ({1'b0, vcount_q} >= v_act_start) && ({1'b0, vcount_q} < v_act_end);
        fetch_valid = h_in && v_in;
        col         = fetch_valid ? hcount_q - H_ACT_START[CW-1:0] : '0;
        row         = fetch_valid ? vcount_q - v_act_start[CW-1:0] : '0;
        hsync_raw   = ({1'b0, hcount_q} < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_raw   = ({1'b0, vcount_q} < v_sync_end) ? v_pol : ~v_pol;
        blank_raw   = ~fetch_valid;
    end

    // Pixel data fetched at (row,col) spends PIPE_DELAY pix_en steps in flight; match it here.
    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL ({~HSYNC_POL, ~VSYNC_POL, 1'b1})
    ) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .din   ({hsync_raw, vsync_raw, blank_raw}),
        .dout  ({hsync, vsync, is_blank})
    );

    assign mode_active  = mode_active_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, a no-delay/inverted-hsync variant, and a tiny raster
// whose short frames make frame-period and mode-switch behaviour reachable in few cycles.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset, pix_en, mode_sel;

    logic        d_mode, d_hsync, d_vsync, d_blank, d_fv, d_ls, d_fs, d_vbs;
    logic [10:0] d_row, d_col;
    logic        a_mode, a_hsync, a_vsync, a_blank, a_fv, a_ls, a_fs, a_vbs;
    logic [10:0] a_row, a_col;
    logic        s_mode, s_hsync, s_vsync, s_blank, s_fv, s_ls, s_fs, s_vbs;
    logic [4:0]  s_row, s_col;

    int checks = 0;
    int errors = 0;
    int steps  = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode_sel(mode_sel),
        .mode_active(d_mode), .hsync(d_hsync), .vsync(d_vsync), .is_blank(d_blank),
        .fetch_valid(d_fv), .row(d_row), .col(d_col),
        .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vbs)
    );

    vga_timing_gen #(.HSYNC_POL(1'b1), .PIPE_DELAY(0)) dut_alt (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode_sel(mode_sel),
        .mode_active(a_mode), .hsync(a_hsync), .vsync(a_vsync), .is_blank(a_blank),
        .fetch_valid(a_fv), .row(a_row), .col(a_col),
        .line_start(a_ls), .frame_start(a_fs), .vblank_start(a_vbs)
    );

    // H 3/2/6/1 = 12, mode0 V 1/2/4/1 = 8 lines (96 steps), mode1 V 1/1/3/1 = 6 lines (72 steps).
    vga_timing_gen #(
        .H_SYNC(3), .H_BACK(2), .H_ACTIVE(6), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
        .ALT_V_SYNC(1), .ALT_V_BACK(1), .ALT_V_ACTIVE(3), .ALT_V_FRONT(1),
        .PIPE_DELAY(2), .CW(5)
    ) dut_small (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode_sel(mode_sel),
        .mode_active(s_mode), .hsync(s_hsync), .vsync(s_vsync), .is_blank(s_blank),
        .fetch_valid(s_fv), .row(s_row), .col(s_col),
        .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vbs)
    );

    task automatic tick();
        logic en;
        en = pix_en & ~reset;
        @(posedge clk);
        #1;
        if (en) steps++;
    endtask

    task automatic step_to(input int target);
        pix_en = 1'b1;
        for (int i = 0; i < 100000 && steps < target; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; pix_en = 1'b0; mode_sel = 1'b0;
        repeat (3) tick();
        pix_en = 1'b1;
        tick();
        checks++; if (d_hsync !== 1'b1 || d_vsync !== 1'b1 || d_blank !== 1'b1) begin errors++;
            $display("FAIL reset_dly got h%b v%b b%b exp h1 v1 b1", d_hsync, d_vsync, d_blank); end
        checks++; if ({d_ls, d_fs, d_vbs, d_mode} !== 4'b0000) begin errors++;
            $display("FAIL reset_pulses got %b exp 0000", {d_ls, d_fs, d_vbs, d_mode}); end
        checks++; if (d_fv !== 1'b0 || d_row !== 11'd0 || d_col !== 11'd0) begin errors++;
            $display("FAIL reset_fetch got fv%b r%0d c%0d exp fv0 r0 c0", d_fv, d_row, d_col); end
        checks++; if (a_hsync !== 1'b1) begin errors++;
            $display("FAIL reset_alt_hsync got %b exp 1", a_hsync); end
        checks++; if (s_hsync !== 1'b1 || s_blank !== 1'b1) begin errors++;
            $display("FAIL reset_small got h%b b%b exp h1 b1", s_hsync, s_blank); end
        reset = 1'b0;
        steps = 0;
    endtask

    task automatic test_raster();
        int hs_low = 0, vs_low = 0, ls_cnt = 0, d_fs_cnt = 0, s_fs_cnt = 0, s_vb_cnt = 0;
        pix_en = 1'b1;
        for (int i = 0; i < 2400; i++) begin
            tick();
            if (steps > 800 && steps <= 1600 && d_hsync === 1'b0) hs_low++;
            if (d_vsync === 1'b0) vs_low++;
            if (d_ls === 1'b1) ls_cnt++;
            if (d_fs === 1'b1) d_fs_cnt++;
            if (s_fs === 1'b1) s_fs_cnt++;
            if (s_vbs === 1'b1) s_vb_cnt++;
            if (steps == 800) begin
                checks++; if (d_ls !== 1'b1) begin errors++; $display("FAIL line_start_800 got %b exp 1", d_ls); end
            end
            if (steps == 801 || steps == 898) begin
                checks++; if (d_hsync !== 1'b1) begin errors++;
                    $display("FAIL hsync_idle_%0d got %b exp 1", steps, d_hsync); end
            end
            if (steps == 802 || steps == 897) begin
                checks++; if (d_hsync !== 1'b0) begin errors++;
                    $display("FAIL hsync_act_%0d got %b exp 0", steps, d_hsync); end
            end
            if (steps == 96 || steps == 192) begin
                checks++; if (s_fs !== 1'b1 || s_ls !== 1'b1) begin errors++;
                    $display("FAIL small_frame_%0d got fs%b ls%b exp fs1 ls1", steps, s_fs, s_ls); end
            end
            if (steps == 84) begin
                checks++; if (s_vbs !== 1'b1) begin errors++; $display("FAIL small_vblank_84 got %b exp 1", s_vbs); end
            end
        end
        checks++; if (hs_low != 96) begin errors++; $display("FAIL hsync_low_count got %0d exp 96", hs_low); end
        checks++; if (vs_low != 1600) begin errors++; $display("FAIL vsync_low_count got %0d exp 1600", vs_low); end
        checks++; if (ls_cnt != 3) begin errors++; $display("FAIL line_start_count got %0d exp 3", ls_cnt); end
        checks++; if (d_fs_cnt != 0) begin errors++; $display("FAIL frame_start_early got %0d exp 0", d_fs_cnt); end
        checks++; if (s_fs_cnt != 25) begin errors++; $display("FAIL small_frame_count got %0d exp 25", s_fs_cnt); end
        checks++; if (s_vb_cnt != 25) begin errors++; $display("FAIL small_vblank_count got %0d exp 25", s_vb_cnt); end
    endtask

    task automatic test_fetch_window();
        step_to(28143);
        checks++; if (d_fv !== 1'b0) begin errors++; $display("FAIL fetch_143 got %b exp 0", d_fv); end
        step_to(28144);
        checks++; if (d_fv !== 1'b1 || d_row !== 11'd0 || d_col !== 11'd0 || d_blank !== 1'b1) begin errors++;
            $display("FAIL fetch_144 got fv%b r%0d c%0d b%b exp fv1 r0 c0 b1", d_fv, d_row, d_col, d_blank); end
        step_to(28145);
        checks++; if (d_blank !== 1'b1) begin errors++; $display("FAIL blank_145 got %b exp 1", d_blank); end
        step_to(28146);
        checks++; if (d_blank !== 1'b0 || d_col !== 11'd2) begin errors++;
            $display("FAIL blank_146 got b%b c%0d exp b0 c2", d_blank, d_col); end
        step_to(28783);
        checks++; if (d_fv !== 1'b1 || d_col !== 11'd639 || d_row !== 11'd0) begin errors++;
            $display("FAIL fetch_783 got fv%b r%0d c%0d exp fv1 r0 c639", d_fv, d_row, d_col); end
        step_to(28784);
        checks++; if (d_fv !== 1'b0 || d_col !== 11'd0 || d_row !== 11'd0) begin errors++;
            $display("FAIL fetch_784 got fv%b r%0d c%0d exp fv0 r0 c0", d_fv, d_row, d_col); end
        step_to(28785);
        checks++; if (d_blank !== 1'b0) begin errors++; $display("FAIL blank_785 got %b exp 0", d_blank); end
        step_to(28786);
        checks++; if (d_blank !== 1'b1) begin errors++; $display("FAIL blank_786 got %b exp 1", d_blank); end
    endtask

    task automatic test_polarity_nodelay();
        logic exp_hs, exp_bl;
        int   h;
        step_to(28800);
        for (int i = 0; i < 800; i++) begin
            h      = steps - 28800;
            exp_hs = (h < 96);
            exp_bl = !(h >= 144 && h < 784);
            checks++; if (a_hsync !== exp_hs) begin errors++;
                $display("FAIL alt_hsync_h%0d got %b exp %b", h, a_hsync, exp_hs); end
            checks++; if (a_blank !== exp_bl) begin errors++;
                $display("FAIL alt_blank_h%0d got %b exp %b", h, a_blank, exp_bl); end
            if (h == 144) begin
                checks++; if (a_row !== 11'd1 || a_col !== 11'd0) begin errors++;
                    $display("FAIL alt_fetch_h144 got r%0d c%0d exp r1 c0", a_row, a_col); end
            end
            tick();
        end
    endtask

    task automatic test_pix_en_toggle();
        int ls_cnt = 0;
        step_to(29600);
        checks++; if (d_ls !== 1'b1) begin errors++; $display("FAIL toggle_start_ls got %b exp 1", d_ls); end
        for (int c = 1; c <= 3200; c++) begin
            pix_en = (c % 2 == 0);
            tick();
            if (d_ls === 1'b1) ls_cnt++;
            if (c == 600 || c == 601) begin
                checks++; if (d_col !== 11'd156 || d_row !== 11'd2) begin errors++;
                    $display("FAIL toggle_hold_c%0d got r%0d c%0d exp r2 c156", c, d_row, d_col); end
            end
            if (c == 1600) begin
                checks++; if (d_ls !== 1'b1) begin errors++; $display("FAIL toggle_ls_1600 got %b exp 1", d_ls); end
            end
            if (c == 1601) begin
                checks++; if (d_ls !== 1'b0) begin errors++; $display("FAIL toggle_ls_1601 got %b exp 0", d_ls); end
            end
        end
        checks++; if (ls_cnt != 2) begin errors++; $display("FAIL toggle_ls_count got %0d exp 2", ls_cnt); end
        pix_en = 1'b1;
    endtask

    task automatic test_reset_midline();
        int early = 0;
        step_to(31700);
        checks++; if (d_fv !== 1'b1 || d_row !== 11'd4 || d_col !== 11'd356) begin errors++;
            $display("FAIL pre_reset got fv%b r%0d c%0d exp fv1 r4 c356", d_fv, d_row, d_col); end
        #2 reset = 1'b1;
        #1;
        checks++; if (d_fv !== 1'b0 || d_blank !== 1'b1 || d_hsync !== 1'b1 || d_ls !== 1'b0) begin errors++;
            $display("FAIL async_reset got fv%b b%b h%b ls%b exp fv0 b1 h1 ls0", d_fv, d_blank, d_hsync, d_ls); end
        tick();
        checks++; if (d_col !== 11'd0 || d_row !== 11'd0 || d_blank !== 1'b1 || {d_ls, d_fs, d_vbs} !== 3'b000) begin
            errors++; $display("FAIL held_reset got r%0d c%0d b%b p%b exp r0 c0 b1 p000",
                               d_row, d_col, d_blank, {d_ls, d_fs, d_vbs}); end
        reset = 1'b0;
        steps = 0;
        pix_en = 1'b1;
        for (int i = 0; i < 799; i++) begin
            tick();
            if (d_ls === 1'b1) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL post_reset_early_ls got %0d exp 0", early); end
        tick();
        checks++; if (d_ls !== 1'b1 || d_fs !== 1'b0) begin errors++;
            $display("FAIL post_reset_ls_800 got ls%b fs%b exp ls1 fs0", d_ls, d_fs); end
    endtask

    task automatic test_mode_switch();
        int fs_cnt = 0, max_row = 0;
        step_to(864);
        checks++; if (s_fs !== 1'b1 || s_mode !== 1'b0) begin errors++;
            $display("FAIL mode_f0 got fs%b m%b exp fs1 m0", s_fs, s_mode); end
        step_to(866);
        checks++; if (s_vsync !== 1'b0) begin errors++; $display("FAIL m0_vsync_act got %b exp 0", s_vsync); end
        step_to(878);
        checks++; if (s_vsync !== 1'b1) begin errors++; $display("FAIL m0_vsync_idle got %b exp 1", s_vsync); end
        step_to(900);
        mode_sel = 1'b1;
        while (steps < 959) begin
            tick();
            if (s_fs === 1'b1) fs_cnt++;
            if (s_fv === 1'b1 && int'(s_row) > max_row) max_row = int'(s_row);
        end
        checks++; if (fs_cnt != 0 || s_mode !== 1'b0) begin errors++;
            $display("FAIL m0_frame_len got fs%0d m%b exp fs0 m0", fs_cnt, s_mode); end
        checks++; if (max_row != 3) begin errors++; $display("FAIL m0_row_max got %0d exp 3", max_row); end
        tick();
        checks++; if (s_fs !== 1'b1 || s_mode !== 1'b1) begin errors++;
            $display("FAIL wrap_960 got fs%b m%b exp fs1 m1", s_fs, s_mode); end
        fs_cnt = 0; max_row = 0;
        while (steps < 1031) begin
            tick();
            if (s_fs === 1'b1) fs_cnt++;
            if (s_fv === 1'b1 && int'(s_row) > max_row) max_row = int'(s_row);
            if (steps == 973) begin
                checks++; if (s_vsync !== 1'b1) begin errors++; $display("FAIL m1_vsync_act got %b exp 1", s_vsync); end
            end
            if (steps == 974) begin
                checks++; if (s_vsync !== 1'b0) begin errors++; $display("FAIL m1_vsync_idle got %b exp 0", s_vsync); end
            end
            if (steps == 1000) mode_sel = 1'b0;
            if (steps == 1020) begin
                checks++; if (s_vbs !== 1'b1) begin errors++; $display("FAIL m1_vblank got %b exp 1", s_vbs); end
            end
        end
        checks++; if (fs_cnt != 0 || s_mode !== 1'b1) begin errors++;
            $display("FAIL m1_frame_len got fs%0d m%b exp fs0 m1", fs_cnt, s_mode); end
        checks++; if (max_row != 2) begin errors++; $display("FAIL m1_row_max got %0d exp 2", max_row); end
        tick();
        checks++; if (s_fs !== 1'b1 || s_mode !== 1'b0) begin errors++;
            $display("FAIL wrap_1032 got fs%b m%b exp fs1 m0", s_fs, s_mode); end
        step_to(1127);
        checks++; if (s_fs !== 1'b0) begin errors++; $display("FAIL m0_again_1127 got %b exp 0", s_fs); end
        step_to(1128);
        checks++; if (s_fs !== 1'b1) begin errors++; $display("FAIL m0_again_1128 got %b exp 1", s_fs); end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_fetch_window();
        test_polarity_nodelay();
        test_pix_en_toggle();
        test_reset_midline();
        test_mode_switch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
